// File: rtl/exec_unit_pipe.sv
// Execution unit: single-cycle ALU ops plus iterative MULTU/DIVU that
// write the architectural Hi/Lo pair. One op in flight at a time.
module exec_unit_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             out_valid,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             busy
);

  localparam int LW = $clog2(WIDTH);
  localparam logic [LW:0] CNT_LAST = (LW+1)'(WIDTH-1);

  localparam logic [5:0] OP_SRL   = 6'd2;
  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MFLO  = 6'd18;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_DIVU  = 6'd27;
  localparam logic [5:0] OP_ADD   = 6'd32;
  localparam logic [5:0] OP_SUB   = 6'd34;
  localparam logic [5:0] OP_AND   = 6'd36;
  localparam logic [5:0] OP_OR    = 6'd37;
  localparam logic [5:0] OP_SLT   = 6'd42;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic [LW:0]      cnt;
  logic [WIDTH-1:0] opd;     // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] acc_hi;  // partial product high half / remainder
  logic [WIDTH-1:0] acc_lo;  // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] alu_res;
  logic             alu_known;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   div_rsh, div_diff;
  logic             div_qbit;
  logic [WIDTH-1:0] div_hi, div_lo;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CNT_LAST);
  assign HiOut  = hi_q;
  assign LoOut  = lo_q;

  // Shift-add multiplier step: add multiplicand on multiplier LSB, shift the
  // {carry,hi,lo} triple right; after WIDTH steps {hi,lo} is the product.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
  end

  // Restoring divider step: shift the next dividend bit into the remainder,
  // trial-subtract, keep the difference when it is non-negative. A zero
  // divisor always succeeds, leaving quotient all ones and remainder = A.
  always_comb begin
    div_rsh  = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_rsh - {1'b0, opd};
    div_qbit = ~div_diff[WIDTH];
    div_hi   = div_qbit ? div_diff[WIDTH-1:0] : div_rsh[WIDTH-1:0];
    div_lo   = {acc_lo[WIDTH-2:0], div_qbit};
  end

  // Select the iteration result for whichever engine is running.
  always_comb begin
    step_hi = (state == DIV) ? div_hi : mul_hi;
    step_lo = (state == DIV) ? div_lo : mul_lo;
  end

  // Single-cycle result; unknown codes produce zero.
  always_comb begin
    alu_res   = '0;
    alu_known = 1'b1;
    unique case (Signal)
      OP_AND:  alu_res = dataA & dataB;
      OP_OR:   alu_res = dataA | dataB;
      OP_ADD:  alu_res = dataA + dataB;
      OP_SUB:  alu_res = dataA - dataB;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      OP_SRL:  alu_res = dataA >> dataB[LW-1:0];
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_known = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) begin
              if (Signal == OP_MULTU)     state_nxt = MUL;
              else if (Signal == OP_DIVU) state_nxt = DIV;
            end
      MUL, DIV: if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake/status outputs depend on state only.
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  // Datapath: operand capture, iteration, Hi/Lo commit, registered result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      opd       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      out_valid <= 1'b0;
      Output    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (accept) begin
            cnt    <= '0;
            acc_hi <= '0;
            if (Signal == OP_MULTU) begin
              opd    <= dataA;
              acc_lo <= dataB;
            end else if (Signal == OP_DIVU) begin
              opd    <= dataB;
              acc_lo <= dataA;
            end else begin
              out_valid <= 1'b1;
              Output    <= alu_known ? alu_res : '0;
            end
          end
        end
        MUL, DIV: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (last) begin
            hi_q      <= step_hi;
            lo_q      <= step_lo;
            out_valid <= 1'b1;
            Output    <= step_lo;
          end
        end
        DONE: out_valid <= 1'b0;
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Scoreboard bench for exec_unit_pipe (WIDTH=32): directed corner cases then
// randomized ops checked against an arithmetic reference model.
module tb_exec_unit_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [5:0]   Signal = '0;
  logic [W-1:0] dataA = '0, dataB = '0;
  logic         out_valid;
  logic [W-1:0] Output, HiOut, LoOut;
  logic         busy;

  exec_unit_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Signal(Signal), .dataA(dataA), .dataB(dataB), .out_valid(out_valid),
    .Output(Output), .HiOut(HiOut), .LoOut(LoOut), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out, hi, lo;
    int           lat;
    int           issued;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   npass = 0, ntotal = 0;
  logic [W-1:0] mh = '0, ml = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model in plain arithmetic; updates model Hi/Lo in program order.
  task automatic model(input logic [5:0] op, input logic [W-1:0] a, b, output exp_t e);
    logic [63:0] p;
    logic [4:0]  sh;
    e.lat = 1;
    e.out = '0;
    sh = b[4:0];
    case (op)
      6'd36: e.out = a & b;
      6'd37: e.out = a | b;
      6'd32: e.out = a + b;
      6'd34: e.out = a - b;
      6'd42: e.out = ($signed(a) < $signed(b)) ? 1 : 0;
      6'd2:  e.out = a >> sh;
      6'd16: e.out = mh;
      6'd18: e.out = ml;
      6'd25: begin
        p = 64'(a) * 64'(b);
        mh = p[63:32]; ml = p[31:0];
        e.out = ml; e.lat = W + 1;
      end
      6'd27: begin
        if (b == 0) begin ml = '1; mh = a; end
        else begin ml = a / b; mh = a % b; end
        e.out = ml; e.lat = W + 1;
      end
      default: e.out = '0;
    endcase
    e.hi = mh;
    e.lo = ml;
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [5:0] op, input logic [W-1:0] a, b);
    int   waitc = 0;
    exp_t e;
    in_valid = 1'b1; Signal = op; dataA = a; dataB = b;
    while (!in_ready && waitc < 200) begin @(negedge clk); waitc++; end
    if (!in_ready) begin
      chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      return;
    end
    model(op, a, b, e);
    e.issued = cyc;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: every out_valid pops one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("output", 64'(Output), 64'(e.out));
        chk("hi", 64'(HiOut), 64'(e.hi));
        chk("lo", 64'(LoOut), 64'(e.lo));
        chk("latency", 64'(cyc - e.issued), 64'(e.lat));
      end
    end
  end

  logic [5:0] codes [11] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2,
                             6'd16, 6'd18, 6'd25, 6'd27, 6'd63};

  function automatic logic [W-1:0] rnd_opd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return W'($urandom_range(0, 20));
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int drain;
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_output", 64'(Output), 64'd0);
    chk("rst_hilo", {HiOut, LoOut}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back single-cycle ops.
    issue(6'd32, 32'hFFFF_FFFF, 32'd1);
    issue(6'd34, 32'd0, 32'd1);
    issue(6'd42, 32'h8000_0000, 32'd1);
    issue(6'd2, 32'h8000_0000, 32'd31);
    issue(6'd1, 32'h1234, 32'h5678);

    // MULTU; next op is held on in_valid throughout busy and must not be taken early.
    issue(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mul_busy", {62'd0, busy, in_ready}, 64'b10);
    issue(6'd27, 32'd100, 32'd7);
    issue(6'd16, 32'hDEAD, 32'hBEEF);
    issue(6'd18, 32'hDEAD, 32'hBEEF);
    issue(6'd27, 32'h1234, 32'd0);
    issue(6'd16, 32'd0, 32'd0);

    // Reset in the middle of a MULTU.
    issue(6'd25, 32'd12345, 32'd6789);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_ready_busy", {62'd0, in_ready, busy}, 64'b10);
    chk("midrst_output", 64'(Output), 64'd0);
    chk("midrst_hilo", {HiOut, LoOut}, 64'd0);
    sb.delete();
    mh = '0; ml = '0;
    @(negedge clk);
    reset = 1'b1;
    issue(6'd32, 32'd2, 32'd3);
    issue(6'd16, 32'd0, 32'd0);

    // Randomized mix.
    for (int i = 0; i < 300; i++) begin
      issue(codes[$urandom_range(0, 10)], rnd_opd(), rnd_opd());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    drain = 0;
    while (sb.size() != 0 && drain < 200) begin @(negedge clk); drain++; end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
